dandy_seg_sequencer: RTL and testbench

//   Parametrised 7-segment animation sequencer for the dandy dance ASIC. It succeeds the

---
 rtl/dandy_seg_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_dandy_seg_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dandy_seg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dandy_seg_sequencer                                                      |
// | Multi-digit 7-segment animation player with writable frame store.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dandy_seg_sequencer #(
    parameter int N_DIGITS = 4,
    parameter int N_FRAMES = 8,
    parameter int PRESC_W  = 16,
    parameter int SCAN_DIV = 64,
    localparam int FRM_W   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    localparam int DIG_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] speed,
    input  logic               start,
    input  logic               pause,
    input  logic               wr_en,
    input  logic [FRM_W-1:0]   wr_frame,
    input  logic [DIG_W-1:0]   wr_digit,
    input  logic [6:0]         wr_data,
    output logic [6:0]         seg,
    output logic [N_DIGITS-1:0] dig_sel,
    output logic [FRM_W-1:0]   frame_idx,
    output logic               busy,
    output logic               done
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0]  c_frm_last  = FRM_W'(N_FRAMES - 1);
    localparam logic [DIG_W-1:0]  c_dig_last  = DIG_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t              r_state, w_state_nx;
    logic [FRM_W-1:0]    r_frame, w_frame_nx;
    logic                r_dir_down, w_dir_down_nx;
    logic [PRESC_W-1:0]  r_presc, w_presc_nx;
    logic                r_done, w_done_nx;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [DIG_W-1:0]    r_scan_dig;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_dig_sel;
    logic [6:0]          r_store [N_FRAMES][N_DIGITS];
    logic                w_restart, w_step, w_wr_ok;

    assign w_wr_ok = (32'(wr_frame) < N_FRAMES) && (32'(wr_digit) < N_DIGITS);

    always_comb begin
        w_state_nx    = r_state;
        w_frame_nx    = r_frame;
        w_dir_down_nx = r_dir_down;
        w_presc_nx    = r_presc;
        w_done_nx     = 1'b0;
        w_restart     = 1'b0;
        w_step        = 1'b0;
        case (r_state)
            S_IDLE:   w_restart = start;
            S_RUN: begin
                if (start)      w_restart  = 1'b1;
                else if (pause) w_state_nx = S_PAUSED;
                else            w_step     = 1'b1;
            end
            S_PAUSED: begin
                // Leaving pause counts this cycle, so a pause of N cycles delays by exactly N.
                if (start) begin
                    w_restart = 1'b1;
                end else if (!pause) begin
                    w_state_nx = S_RUN;
                    w_step     = 1'b1;
                end
            end
            default:  w_state_nx = S_IDLE;
        endcase

        if (w_restart) begin
            w_state_nx    = pause ? S_PAUSED : S_RUN;
            w_frame_nx    = '0;
            w_dir_down_nx = 1'b0;
            w_presc_nx    = '0;
        end else if (w_step) begin
            if (r_presc >= speed) begin
                w_presc_nx = '0;
                case (mode)
                    2'b00: begin
                        w_dir_down_nx = 1'b0;
                        w_frame_nx    = (r_frame == c_frm_last) ? '0 : r_frame + 1'b1;
                    end
                    2'b01: begin
                        if (N_FRAMES > 1) begin
                            if (!r_dir_down) begin
                                if (r_frame == c_frm_last) begin
                                    w_dir_down_nx = 1'b1;
                                    w_frame_nx    = r_frame - 1'b1;
                                end else begin
                                    w_frame_nx    = r_frame + 1'b1;
                                end
                            end else begin
                                if (r_frame == '0) begin
                                    w_dir_down_nx = 1'b0;
                                    w_frame_nx    = r_frame + 1'b1;
                                end else begin
                                    w_frame_nx    = r_frame - 1'b1;
                                end
                            end
                        end
                    end
                    2'b10: begin
                        w_dir_down_nx = 1'b0;
                        if (r_frame == c_frm_last) begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_frame_nx = r_frame + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                w_presc_nx = r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_dir_down <= 1'b0;
            r_presc    <= '0;
            r_done     <= 1'b0;
            r_scan_cnt <= '0;
            r_scan_dig <= '0;
            r_seg      <= '0;
            r_dig_sel  <= '0;
        end else if (ena) begin
            r_state    <= w_state_nx;
            r_frame    <= w_frame_nx;
            r_dir_down <= w_dir_down_nx;
            r_presc    <= w_presc_nx;
            r_done     <= w_done_nx;
            if (r_scan_cnt == c_scan_last) begin
                r_scan_cnt <= '0;
                r_scan_dig <= (r_scan_dig == c_dig_last) ? '0 : r_scan_dig + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_dig_sel <= N_DIGITS'(1) << r_scan_dig;
            r_seg     <= r_store[r_frame][r_scan_dig];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < N_FRAMES; f++) begin
                for (int d = 0; d < N_DIGITS; d++) begin
                    r_store[f][d] <= '0;
                end
            end
        end else if (ena && wr_en && w_wr_ok) begin
            r_store[wr_frame][wr_digit] <= wr_data;
        end
    end

    assign seg       = r_seg;
    assign dig_sel   = r_dig_sel;
    assign frame_idx = r_frame;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dandy_seg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dandy_seg_sequencer                                                   |
// | Self-checking bench: vector table, scoreboard and corner-case sequences. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dandy_seg_sequencer;

    localparam int N_DIGITS = 4;
    localparam int N_FRAMES = 8;
    localparam int PRESC_W  = 16;
    localparam int SCAN_DIV = 4;

    logic         clk, rst, ena, start, pause, wr_en;
    logic [1:0]   mode;
    logic [15:0]  speed;
    logic [2:0]   wr_frame;
    logic [1:0]   wr_digit;
    logic [6:0]   wr_data;
    logic [6:0]   seg;
    logic [3:0]   dig_sel;
    logic [2:0]   frame_idx;
    logic         busy, done;

    dandy_seg_sequencer #(
        .N_DIGITS (N_DIGITS),
        .N_FRAMES (N_FRAMES),
        .PRESC_W  (PRESC_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .mode      (mode),
        .speed     (speed),
        .start     (start),
        .pause     (pause),
        .wr_en     (wr_en),
        .wr_frame  (wr_frame),
        .wr_digit  (wr_digit),
        .wr_data   (wr_data),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .frame_idx (frame_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] speed;
        int          k;
        logic [2:0]  frame;
        logic        busy;
        logic        done;
    } run_vec_t;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
    } scan_exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  model [N_FRAMES][N_DIGITS];
    scan_exp_t   sb [$];
    int          fq [$];
    run_vec_t    runs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [2:0] f, input logic [1:0] d, input logic [6:0] v);
        wr_en = 1'b1; wr_frame = f; wr_digit = d; wr_data = v;
        step(1);
        wr_en = 1'b0;
        model[f][d] = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Align to the sample where dig_sel has just wrapped to digit 0.
    task automatic sync_scan();
        logic [3:0] prev;
        bit         found;
        prev  = dig_sel;
        found = 1'b0;
        for (int i = 0; i < 4 * SCAN_DIV * N_DIGITS && !found; i++) begin
            step(1);
            if (dig_sel == 4'b0001 && prev != 4'b0001) found = 1'b1;
            else prev = dig_sel;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_sync: dig_sel never wrapped to 0001, got %b", dig_sel);
        end
    endtask

    task automatic check_frame_scan(input int f);
        scan_exp_t e;
        logic [3:0] oh;
        sync_scan();
        for (int k = 0; k < SCAN_DIV * N_DIGITS; k++) begin
            oh    = 4'b0001 << (k / SCAN_DIV);
            e.dig = oh;
            e.seg = model[f][k / SCAN_DIV];
            sb.push_back(e);
        end
        for (int k = 0; k < SCAN_DIV * N_DIGITS; k++) begin
            e = sb.pop_front();
            chk($sformatf("scan_dig f%0d k%0d", f, k), 32'(dig_sel), 32'(e.dig));
            chk($sformatf("scan_seg f%0d k%0d", f, k), 32'(seg), 32'(e.seg));
            if (k < SCAN_DIV * N_DIGITS - 1) step(1);
        end
    endtask

    // Park playback on frame f in PAUSED (loop, speed 0) and read its patterns via the scan.
    task automatic readback(input int f);
        mode = 2'b00; speed = 16'd0; pause = 1'b0;
        pulse_start();
        chk("rb_start_frame", 32'(frame_idx), 32'd0);
        step(f);
        pause = 1'b1;
        step(1);
        chk($sformatf("rb_frame%0d", f), 32'(frame_idx), 32'(f));
        chk("rb_busy", 32'(busy), 32'd1);
        check_frame_scan(f);
        pause = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] held_dig;

        rst = 1'b1; ena = 1'b1; start = 1'b0; pause = 1'b0; wr_en = 1'b0;
        mode = 2'b00; speed = 16'd0; wr_frame = '0; wr_digit = '0; wr_data = '0;
        for (int f = 0; f < N_FRAMES; f++)
            for (int d = 0; d < N_DIGITS; d++)
                model[f][d] = 7'h00;

        runs[0]  = '{2'b00, 16'd9,  0, 3'd0, 1'b1, 1'b0};
        runs[1]  = '{2'b00, 16'd9,  9, 3'd0, 1'b1, 1'b0};
        runs[2]  = '{2'b00, 16'd9, 10, 3'd1, 1'b1, 1'b0};
        runs[3]  = '{2'b00, 16'd9, 79, 3'd7, 1'b1, 1'b0};
        runs[4]  = '{2'b00, 16'd9, 80, 3'd0, 1'b1, 1'b0};
        runs[5]  = '{2'b00, 16'd0,  9, 3'd1, 1'b1, 1'b0};
        runs[6]  = '{2'b01, 16'd0,  7, 3'd7, 1'b1, 1'b0};
        runs[7]  = '{2'b01, 16'd0,  8, 3'd6, 1'b1, 1'b0};
        runs[8]  = '{2'b01, 16'd0, 14, 3'd0, 1'b1, 1'b0};
        runs[9]  = '{2'b01, 16'd0, 15, 3'd1, 1'b1, 1'b0};
        runs[10] = '{2'b11, 16'd0, 20, 3'd0, 1'b1, 1'b0};
        runs[11] = '{2'b10, 16'd0,  7, 3'd7, 1'b1, 1'b0};
        runs[12] = '{2'b10, 16'd0,  8, 3'd7, 1'b0, 1'b1};
        runs[13] = '{2'b10, 16'd0,  9, 3'd7, 1'b0, 1'b0};
        runs[14] = '{2'b00, 16'd3,  9, 3'd2, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_dig_sel", 32'(dig_sel), 32'd0);
        chk("rst_frame", 32'(frame_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #2 rst = 1'b0;
        step(1);

        // Frame store contents
        write(3'd0, 2'd0, 7'h3F);
        write(3'd0, 2'd1, 7'h06);
        write(3'd0, 2'd2, 7'h5B);
        write(3'd0, 2'd3, 7'h4F);
        for (int f = 1; f < N_FRAMES; f++)
            for (int d = 0; d < N_DIGITS; d++)
                write(3'(f), 2'(d), 7'((f * 9 + d * 17 + 3) & 7'h7F));

        // Scan of frame 0 while idle
        check_frame_scan(0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Vector table
        foreach (runs[i]) begin
            mode  = runs[i].mode;
            speed = runs[i].speed;
            pulse_start();
            step(runs[i].k);
            chk($sformatf("run%0d_frame", i), 32'(frame_idx), 32'(runs[i].frame));
            chk($sformatf("run%0d_busy", i), 32'(busy), 32'(runs[i].busy));
            chk($sformatf("run%0d_done", i), 32'(done), 32'(runs[i].done));
        end

        // Ping-pong full sweep, every cycle
        mode = 2'b01; speed = 16'd0;
        for (int k = 0; k <= 7; k++) fq.push_back(k);
        for (int k = 6; k >= 0; k--) fq.push_back(k);
        fq.push_back(1); fq.push_back(2);
        pulse_start();
        while (fq.size() > 0) begin
            chk("pingpong_seq", 32'(frame_idx), 32'(fq.pop_front()));
            if (fq.size() > 0) step(1);
        end

        // Mode change mid-run: loop forces up, ping-pong keeps direction
        mode = 2'b01; speed = 16'd0;
        pulse_start();
        step(9);
        chk("mc_pp_down", 32'(frame_idx), 32'd5);
        mode = 2'b00;
        step(1);
        chk("mc_loop_up", 32'(frame_idx), 32'd6);
        mode = 2'b01;
        step(1);
        chk("mc_pp_keep_up", 32'(frame_idx), 32'd7);
        step(1);
        chk("mc_pp_turn", 32'(frame_idx), 32'd6);

        // Lowering speed mid-frame ticks on the next cycle
        mode = 2'b00; speed = 16'd20;
        pulse_start();
        step(5);
        chk("spd_hold", 32'(frame_idx), 32'd0);
        speed = 16'd2;
        step(1);
        chk("spd_lower_tick", 32'(frame_idx), 32'd1);

        // One-shot, speed 2: done exactly 3 cycles after frame 7 is entered
        mode = 2'b10; speed = 16'd2;
        pulse_start();
        for (int k = 1; k <= 30; k++) begin
            step(1);
            chk($sformatf("os_frame k%0d", k), 32'(frame_idx), (k >= 24) ? 32'd7 : 32'(k / 3));
            chk($sformatf("os_done k%0d", k), 32'(done), (k == 24) ? 32'd1 : 32'd0);
            chk($sformatf("os_busy k%0d", k), 32'(busy), (k < 24) ? 32'd1 : 32'd0);
        end

        // Pause 20 cycles then ena low 10 cycles: tick slips by 30
        mode = 2'b00; speed = 16'd9;
        pulse_start();
        step(3);
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("pause_frame", 32'(frame_idx), 32'd0);
            chk("pause_busy", 32'(busy), 32'd1);
        end
        pause = 1'b0; ena = 1'b0;
        held_dig = dig_sel;
        wr_en = 1'b1; wr_frame = 3'd0; wr_digit = 2'd1; wr_data = 7'h7F;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("ena0_dig_sel", 32'(dig_sel), 32'(held_dig));
            chk("ena0_frame", 32'(frame_idx), 32'd0);
        end
        wr_en = 1'b0; ena = 1'b1;
        step(6);
        chk("slip_pre_tick", 32'(frame_idx), 32'd0);
        step(1);
        chk("slip_tick", 32'(frame_idx), 32'd1);

        // Read back every frame (also confirms the write under ena=0 was dropped)
        for (int f = 0; f < N_FRAMES; f++) readback(f);

        // Asynchronous reset mid-run, during a write
        mode = 2'b00; speed = 16'd3;
        pulse_start();
        step(5);
        wr_en = 1'b1; wr_frame = 3'd2; wr_digit = 2'd2; wr_data = 7'h55;
        #2 rst = 1'b1;
        #1;
        chk("arst_seg", 32'(seg), 32'd0);
        chk("arst_dig_sel", 32'(dig_sel), 32'd0);
        chk("arst_frame", 32'(frame_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(posedge clk);
        #3;
        wr_en = 1'b0;
        rst = 1'b0;
        for (int f = 0; f < N_FRAMES; f++)
            for (int d = 0; d < N_DIGITS; d++)
                model[f][d] = 7'h00;
        step(1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_frame_scan(0);
        readback(2);
        readback(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
